alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 168 ++++++++++++++++
 tb/tb_alu_issue.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: two-stage RV32I ALU issue block (D: decode regs -> ALU, W: result).
// Optional feature: define ALU_ISSUE_ILLEGAL_TRAP_EN to add out_illegal and
// zero the result of illegal instructions.
`timescale 1ns/1ps
module alu_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] alu_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic            out_illegal
`endif
);

  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_XOR  = 4'd2;
  localparam logic [3:0] SEL_OR   = 4'd3;
  localparam logic [3:0] SEL_AND  = 4'd4;
  localparam logic [3:0] SEL_SLL  = 4'd5;
  localparam logic [3:0] SEL_SRL  = 4'd6;
  localparam logic [3:0] SEL_SRA  = 4'd7;
  localparam logic [3:0] SEL_SLTU = 4'd8;
  localparam logic [3:0] SEL_SLT  = 4'd9;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] F7_STD = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  logic            d_valid;
  logic [4:0]      d_rd;
  logic            d_adv;
  logic            accept;
  logic [3:0]      dec_sel;
  logic [XLEN-1:0] dec_b;
  logic            dec_illegal;
  logic            unused_rs_fields;

  // Register-number fields are resolved upstream; only their values arrive here.
  assign unused_rs_fields = ^in_instr[19:15];

  // D hands its entry to W whenever W is empty or being drained this cycle.
  assign d_adv    = d_valid & (~out_valid | out_ready);
  assign in_ready = ~rst & (~d_valid | d_adv);
  assign accept   = in_valid & in_ready;

  // Decode: ALU op, operand B and legality from the instruction word.
  always_comb begin
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            is_r;
    logic            is_i;
    logic            alt;
    logic [XLEN-1:0] op_b;

    opcode      = in_instr[6:0];
    f3          = in_instr[14:12];
    f7          = in_instr[31:25];
    is_r        = (opcode == OP_R);
    is_i        = (opcode == OP_I);
    alt         = in_instr[30];
    dec_sel     = SEL_ADD;
    dec_illegal = 1'b0;
    op_b        = is_r ? in_rs2_val
                       : {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

    if (!is_r && !is_i) begin
      dec_illegal = 1'b1;
    end else if (is_r) begin
      dec_illegal = !((f7 == F7_STD) ||
                      ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
    end else if ((f3 == 3'b001) || (f3 == 3'b101)) begin
      dec_illegal = !((f7 == F7_STD) || ((f7 == F7_ALT) && (f3 == 3'b101)));
    end

    unique case (f3)
      3'b000:  dec_sel = (is_r && alt) ? SEL_SUB : SEL_ADD;
      3'b001:  dec_sel = SEL_SLL;
      3'b010:  dec_sel = SEL_SLT;
      3'b011:  dec_sel = SEL_SLTU;
      3'b100:  dec_sel = SEL_XOR;
      3'b101:  dec_sel = alt ? SEL_SRA : SEL_SRL;
      3'b110:  dec_sel = SEL_OR;
      default: dec_sel = SEL_AND;
    endcase

    // Illegal words execute as a plain register-register ADD.
    if (dec_illegal) begin
      dec_sel = SEL_ADD;
      op_b    = in_rs2_val;
    end

    if ((dec_sel == SEL_SLL) || (dec_sel == SEL_SRL) || (dec_sel == SEL_SRA)) begin
      dec_b = {{(XLEN-5){1'b0}}, op_b[4:0]};
    end else begin
      dec_b = op_b;
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic d_illegal;
`endif

  // D stage: capture accepted instruction; alu_* hold while D is empty or stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid <= 1'b0;
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_sel <= SEL_ADD;
      d_rd    <= '0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      d_illegal <= 1'b0;
`endif
    end else begin
      d_valid <= accept | (d_valid & ~d_adv);
      if (accept) begin
        alu_in1 <= in_rs1_val;
        alu_in2 <= dec_b;
        alu_sel <= dec_sel;
        d_rd    <= in_instr[11:7];
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        d_illegal <= dec_illegal;
`endif
      end
    end
  end

  // W stage: capture ALU result when D advances; drop valid after a bare handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      out_illegal <= 1'b0;
`endif
    end else if (d_adv) begin
      out_valid <= 1'b1;
      out_rd    <= d_rd;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      out_result  <= d_illegal ? '0 : alu_out;
      out_illegal <= d_illegal;
`else
      out_result <= alu_out;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, stall/reset
// sequences and a randomized run against an instruction-level reference model.
`timescale 1ns/1ps
module tb_alu_issue;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rs1_val = '0;
  logic [31:0] in_rs2_val = '0;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_out(alu_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    , .out_illegal(out_illegal)
`endif
  );

  always #5 clk = ~clk;

  // External ALU the block drives.
  always_comb begin
    case (alu_sel)
      4'd0:    alu_out = alu_in1 + alu_in2;
      4'd1:    alu_out = alu_in1 - alu_in2;
      4'd2:    alu_out = alu_in1 ^ alu_in2;
      4'd3:    alu_out = alu_in1 | alu_in2;
      4'd4:    alu_out = alu_in1 & alu_in2;
      4'd5:    alu_out = alu_in1 << alu_in2;
      4'd6:    alu_out = alu_in1 >> alu_in2;
      4'd7:    alu_out = 32'($signed(alu_in1) >>> alu_in2);
      4'd8:    alu_out = {31'b0, alu_in1 < alu_in2};
      4'd9:    alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: {illegal, result}.
  function automatic logic [32:0] ref_exec(input logic [31:0] instr,
                                           input logic [31:0] rs1,
                                           input logic [31:0] rs2);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] b;
    logic [31:0] r;
    logic        ill;
    int          sh;
    op  = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    ill = 1'b0;
    if (op == 7'h33) begin
      if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ill = 1'b1;
    end else if (op == 7'h13) begin
      if ((f3 == 3'd1 || f3 == 3'd5) && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5))) ill = 1'b1;
    end else begin
      ill = 1'b1;
    end
    if (ill) return {1'b1, TRAP ? 32'h0 : rs1 + rs2};
    b  = (op == 7'h33) ? rs2 : {{20{instr[31]}}, instr[31:20]};
    sh = int'(b[4:0]);
    case (f3)
      3'd0:    r = (op == 7'h33 && instr[30]) ? rs1 - b : rs1 + b;
      3'd1:    r = rs1 << sh;
      3'd2:    r = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    r = (rs1 < b) ? 32'd1 : 32'd0;
      3'd4:    r = rs1 ^ b;
      3'd5:    r = instr[30] ? 32'($signed(rs1) >>> sh) : rs1 >> sh;
      3'd6:    r = rs1 | b;
      default: r = rs1 & b;
    endcase
    return {1'b0, r};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [2:0]  f3;
    int          k;
    w  = $urandom;
    f3 = w[14:12];
    k  = $urandom_range(0, 9);
    if (k < 5) begin
      w[6:0]   = 7'h33;
      w[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end else if (k < 9) begin
      w[6:0] = 7'h13;
      if (f3 == 3'd1) w[31:25] = 7'h00;
      else if (f3 == 3'd5) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end else begin
      case ($urandom_range(0, 2))
        0: if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[6:0] = 7'h7F;
        1: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
        default: begin w[6:0] = 7'h13; w[14:12] = 3'd1; w[31:25] = 7'h20; end
      endcase
    end
    return w;
  endfunction

  // Scoreboard monitor, sampling one time unit before each rising edge.
  logic [37:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_rd;

  initial begin
    logic [37:0] e;
    logic [32:0] r;
    forever begin
      @(negedge clk);
      #4;
      if (rst !== 1'b0) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_result", out_result, prev_res);
          chk("stall_rd", 32'(out_rd), 32'(prev_rd));
        end
        if (out_valid && out_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output: got result 0x%08h with no pending entry", out_result);
          end else begin
            e = exp_q.pop_front();
            chk("sb_result", out_result, e[31:0]);
            chk("sb_rd", 32'(out_rd), 32'(e[36:32]));
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            chk("sb_illegal", 32'(out_illegal), 32'(e[37]));
`endif
          end
        end
        if (in_valid && in_ready) begin
          r = ref_exec(in_instr, in_rs1_val, in_rs2_val);
          exp_q.push_back({r[32], in_instr[11:7], r[31:0]});
        end
        stall_prev = out_valid && !out_ready;
        prev_res   = out_result;
        prev_rd    = out_rd;
      end
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  sel;
    logic [31:0] in2;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vecs[10];

  task automatic offer(input int i);
    in_valid   = 1'b1;
    in_instr   = vecs[i].instr;
    in_rs1_val = vecs[i].rs1;
    in_rs2_val = vecs[i].rs2;
  endtask

  initial begin
    logic exp_rdy[7];
    int   hs0;
    int   op_i;
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    vecs[0] = '{32'h002081B3, 32'd5,        32'd7,        4'd0, 32'd7,        32'd12,       5'd3,  1'b0};
    vecs[1] = '{32'h4030D093, 32'h80000000, 32'h00001234, 4'd7, 32'd3,        32'hF0000000, 5'd1,  1'b0};
    vecs[2] = '{32'hFFF0B093, 32'd1,        32'd0,        4'd8, 32'hFFFFFFFF, 32'd1,        5'd1,  1'b0};
    vecs[3] = '{32'h402082B3, 32'd3,        32'd10,       4'd1, 32'd10,       32'hFFFFFFF9, 5'd5,  1'b0};
    vecs[4] = '{32'h00209333, 32'd1,        32'hFFFFFF24, 4'd5, 32'd4,        32'h10,       5'd6,  1'b0};
    vecs[5] = '{32'h0020A3B3, 32'hFFFFFFFF, 32'd1,        4'd9, 32'd1,        32'd1,        5'd7,  1'b0};
    vecs[6] = '{32'h0F00C413, 32'hFF00FF00, 32'd0,        4'd2, 32'hF0,       32'hFF00FFF0, 5'd8,  1'b0};
    vecs[7] = '{32'h000004FF, 32'd100,      32'd23,       4'd0, 32'd23,       TRAP ? 32'd0 : 32'd123, 5'd9,  1'b1};
    vecs[8] = '{32'h02208533, 32'd6,        32'd7,        4'd0, 32'd7,        TRAP ? 32'd0 : 32'd13,  5'd10, 1'b1};
    vecs[9] = '{32'hFF00F593, 32'h12345678, 32'd0,        4'd4, 32'hFFFFFFF0, 32'h12345670, 5'd11, 1'b0};

    // Asynchronous reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, one at a time.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      offer(i);
      out_ready = 1'b1;
      #1 chk("vec_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("vec_alu_sel", 32'(alu_sel), 32'(vecs[i].sel));
      chk("vec_alu_in1", alu_in1, vecs[i].rs1);
      chk("vec_alu_in2", alu_in2, vecs[i].in2);
      @(negedge clk);
      #1;
      chk("vec_out_valid", 32'(out_valid), 32'd1);
      chk("vec_out_result", out_result, vecs[i].res);
      chk("vec_out_rd", 32'(out_rd), 32'(vecs[i].rd));
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      chk("vec_out_illegal", 32'(out_illegal), 32'(vecs[i].ill));
`endif
    end
    repeat (3) @(negedge clk);
    #1 chk("drain1_out_valid", 32'(out_valid), 32'd0);

    // Four-op stream with a three-cycle downstream stall.
    hs0  = hs_count;
    op_i = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 4);
      if (op_i < 4) offer(op_i);
      else in_valid = 1'b0;
      #1;
      if (c < 7) chk("s4_in_ready", 32'(in_ready), 32'(exp_rdy[c]));
      if (in_valid && in_ready) op_i++;
    end
    chk("s4_accepted", 32'(op_i), 32'd4);
    chk("s4_handshakes", 32'(hs_count - hs0), 32'd4);
    chk("s4_out_valid_idle", 32'(out_valid), 32'd0);

    // Reset with both stages occupied.
    @(negedge clk);
    out_ready = 1'b0;
    offer(1);
    @(negedge clk);
    offer(3);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("s5_full_out_valid", 32'(out_valid), 32'd1);
    chk("s5_full_alu_sel", 32'(alu_sel), 32'd1);
    hs0 = hs_count;
    #1 rst = 1'b1;
    #1;
    chk("s5_out_valid", 32'(out_valid), 32'd0);
    chk("s5_alu_sel", 32'(alu_sel), 32'd0);
    chk("s5_alu_in2", alu_in2, 32'd0);
    chk("s5_out_result", out_result, 32'd0);
    chk("s5_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("s5_rel_in_ready", 32'(in_ready), 32'd1);
    chk("s5_rel_out_valid", 32'(out_valid), 32'd0);
    chk("s5_no_handshake", 32'(hs_count - hs0), 32'd0);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      in_valid   = ($urandom_range(0, 9) < 7);
      in_instr   = gen_instr();
      in_rs1_val = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      in_rs2_val = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      out_ready  = ($urandom_range(0, 9) < 6);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("rand_drain_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_drain_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
